morse_number_sequencer: RTL and testbench
=========================================

Name: morse_number_sequencer

Overview:
- Sequential target-number generator for the Morse game; supplies the number the player must key in each round.
- Successor to the fixed 4-bit combinational hard-mode number map. Adds:
  - parametrised width;
  - easy/hard range selected at run time;
  - a free-running LFSR source;
  - rejection of out-of-range and repeated values, with a bounded retry count and fallback;
  - a valid/ack handshake and a round counter.
- Sits between the round controller and the Morse ROM address logic.

Parameters:
- WIDTH, 4: number/LFSR width in bits.
- EASY_MAX, 9: largest legal number in easy mode.
- HARD_MAX, 14: largest legal number in hard mode. Must be < 2^WIDTH.
- TAPS, 4'b1100: LFSR feedback mask, WIDTH bits wide.
- SEED, 4'b0001: LFSR reset value. An all-zero SEED is replaced by 1.
- MAX_TRIES, 8: candidates examined per draw before fallback. Must be >= 1.

Ports:
- clk  in  1: clock; all logic on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- next_req  in  1: request a new number; level-sampled in IDLE.
- hard_mode  in  1: 1 selects HARD_MAX, 0 selects EASY_MAX; latched when a request is accepted.
- ack  in  1: consumer has taken number; sampled in PRESENT.
- number  out  WIDTH: current target number.
- number_valid  out  1: high while in PRESENT.
- busy  out  1: high while in DRAW.
- fallback  out  1: high in PRESENT if the number came from fallback.
- round_cnt  out  8: completed rounds (acks); saturates at 255.

Behaviour:
- Reset (async, while rst=1): state IDLE; lfsr=SEED (or 1); number=0; number_valid=0; busy=0; fallback=0; round_cnt=0; prev_valid=0; try count=0.
- LFSR free-runs every cycle in every state:
  - lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
  - With the defaults, the period is 15: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then repeats.
- IDLE:
  - next_req=1 at an edge: latch max = hard_mode ? HARD_MAX : EASY_MAX; clear try count; go to DRAW.
- DRAW (busy=1): each edge, candidate = current lfsr register value (pre-update).
  - Accept if candidate <= max AND NOT (prev_valid AND candidate == prev).
  - On accept: number <= candidate; prev <= candidate; prev_valid <= 1; fallback <= 0; go to PRESENT.
  - On reject with try count == MAX_TRIES-1: number <= 0; fallback <= 1; go to PRESENT. prev is not updated. The no-repeat rule does not apply to fallback.
  - Otherwise: increment try count and stay in DRAW.
- PRESENT (number_valid=1): number is held stable.
  - ack=1: go to IDLE; round_cnt <= round_cnt+1 unless it is 255.
  - next_req is ignored in PRESENT, including when it is high in the same cycle as ack. A new request must be sampled in IDLE.
- Latency:
  - next_req sampled at edge N → DRAW after edge N.
  - First-try accept → number_valid high after edge N+1.
  - Each reject adds one cycle.
  - Worst case is valid after edge N+MAX_TRIES.
- hard_mode changes after acceptance do not affect the draw in progress.
- Reset mid-DRAW or mid-PRESENT returns immediately to the reset values above; no partial number is kept.
- All comparisons are unsigned, WIDTH bits.

Test Plan:
1. Reset release; next_req=1, hard_mode=1 at edge 1 (lfsr=1 → 2) → DRAW candidate 2 accepted; number=2, number_valid=1 after edge 2, busy was high for one cycle.
2. Easy mode, DRAW starts with lfsr=13 → 13 and 10 rejected, 5 accepted; number_valid rises 3 edges after DRAW entry, number=5, fallback=0.
3. MAX_TRIES=3, easy mode, DRAW starts at lfsr=15 → 15, 14, 12 rejected; number=0, fallback=1; prev unchanged.
4. Accept 5, then hold so the next DRAW starts exactly 15 cycles after that accept (candidate 5 again) → 5 rejected as a repeat, 11 rejected in easy mode, 7 accepted.
5. In PRESENT: next_req and ack both high at one edge → IDLE, round_cnt +1, no new draw. Then 256 ack'd rounds → round_cnt stays 255.
6. Assert rst asynchronously mid-DRAW (between edges) → number_valid=0, busy=0, number=0, lfsr=1 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/morse_number_sequencer.sv
// Target-number generator for the Morse game.
// A free-running LFSR supplies candidates. Each draw rejects values that are
// above the selected range or that repeat the previous accepted number.
// After MAX_TRIES rejected candidates the draw falls back to 0.
// The result is offered with a valid/ack handshake, and acknowledged rounds
// are counted in a saturating counter.
module morse_number_sequencer #(
   parameter int               WIDTH     = 4,
   parameter int               EASY_MAX  = 9,
   parameter int               HARD_MAX  = 14,
   parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
   parameter logic [WIDTH-1:0] SEED      = 4'b0001,
   parameter int               MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             next_req,
   input  logic             hard_mode,
   input  logic             ack,
   output logic [WIDTH-1:0] number,
   output logic             number_valid,
   output logic             busy,
   output logic             fallback,
   output logic [7:0]       round_cnt
);

   // An all-zero seed would lock the LFSR up, so it is forced to 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [WIDTH-1:0] EASY_LIM = WIDTH'(EASY_MAX);
   localparam logic [WIDTH-1:0] HARD_LIM = WIDTH'(HARD_MAX);
   localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      PRESENT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] max_lim;
   logic [WIDTH-1:0] prev;
   logic             prev_valid;
   logic [TRY_W-1:0] try_cnt;
   logic             accept;

   // A candidate is the LFSR value before its update on this edge.
   assign accept = (lfsr <= max_lim) && !(prev_valid && (lfsr == prev));

   // The LFSR advances on every cycle in every state, so the phase at which a
   // draw begins depends on how long the game sat idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED_EFF;
      end else begin
         lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      end
   end

   // Round FSM: IDLE -> DRAW -> PRESENT -> IDLE, with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         number       <= '0;
         number_valid <= 1'b0;
         busy         <= 1'b0;
         fallback     <= 1'b0;
         round_cnt    <= 8'd0;
         max_lim      <= '0;
         prev         <= '0;
         prev_valid   <= 1'b0;
         try_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (next_req) begin
                  max_lim <= hard_mode ? HARD_LIM : EASY_LIM;
                  try_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= DRAW;
               end
            end
            DRAW: begin
               if (accept) begin
                  number       <= lfsr;
                  prev         <= lfsr;
                  prev_valid   <= 1'b1;
                  fallback     <= 1'b0;
                  busy         <= 1'b0;
                  number_valid <= 1'b1;
                  state        <= PRESENT;
               end else if (try_cnt == LAST_TRY) begin
                  // The fallback value does not become the new "previous"
                  // number, and it is exempt from the no-repeat rule.
                  number       <= '0;
                  fallback     <= 1'b1;
                  busy         <= 1'b0;
                  number_valid <= 1'b1;
                  state        <= PRESENT;
               end else begin
                  try_cnt <= try_cnt + 1'b1;
               end
            end
            PRESENT: begin
               // next_req is deliberately ignored here; requests count only in IDLE.
               if (ack) begin
                  number_valid <= 1'b0;
                  fallback     <= 1'b0;
                  if (round_cnt != 8'hFF) begin
                     round_cnt <= round_cnt + 8'd1;
                  end
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_number_sequencer.sv
// Scoreboard bench for morse_number_sequencer.
// The reference model predicts each draw from the published LFSR sequence,
// indexed by the number of clock edges since reset release.
module tb_morse_number_sequencer;

   localparam int MT = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       next_req = 1'b0;
   logic       hard_mode = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] number;
   logic       number_valid;
   logic       busy;
   logic       fallback;
   logic [7:0] round_cnt;

   morse_number_sequencer #(
      .WIDTH(4), .EASY_MAX(9), .HARD_MAX(14),
      .TAPS(4'b1100), .SEED(4'b0001), .MAX_TRIES(MT)
   ) dut (
      .clk(clk), .rst(rst), .next_req(next_req), .hard_mode(hard_mode),
      .ack(ack), .number(number), .number_valid(number_valid), .busy(busy),
      .fallback(fallback), .round_cnt(round_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int num;
      int fb;
      int valid_edge;
      int busy_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt;
   int   seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
   bit   m_prev_valid = 1'b0;
   int   m_prev = 0;
   int   m_rounds = 0;

   // Edges since reset release; the LFSR value before edge k+1 is seq[k mod 15].
   always @(posedge clk or posedge rst) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_now();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // Predict a draw whose request is sampled after e0 completed edges.
   function automatic exp_t model(input int e0, input bit h);
      exp_t r;
      int   mx;
      int   c;
      mx = h ? 14 : 9;
      r.num = 0;
      r.fb = 1;
      r.valid_edge = 0;
      r.busy_cyc = 0;
      for (int j = 1; j <= MT; j++) begin
         c = seq[(e0 + j) % 15];
         r.valid_edge = e0 + 1 + j;
         r.busy_cyc = j;
         if (c <= mx && !(m_prev_valid && c == m_prev)) begin
            r.num = c;
            r.fb = 0;
            m_prev = c;
            m_prev_valid = 1'b1;
            break;
         end
      end
      return r;
   endfunction

   // Monitor: compares each newly presented number against the scoreboard.
   initial begin
      logic       nv_d;
      int         busy_seen;
      logic [3:0] held;
      exp_t       e;
      nv_d = 1'b0;
      busy_seen = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            nv_d = 1'b0;
            busy_seen = 0;
         end else begin
            if (busy === 1'b1) busy_seen++;
            if (number_valid === 1'b1 && !nv_d) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got number %0d expected no output", number);
               end else begin
                  e = sb.pop_front();
                  check("number", 32'(number), e.num);
                  check("fallback", 32'(fallback), e.fb);
                  check("valid_edge", edge_cnt, e.valid_edge);
                  check("busy_cycles", busy_seen, e.busy_cyc);
               end
               held = number;
               busy_seen = 0;
            end else if (number_valid === 1'b1) begin
               check("number_hold", 32'(number), 32'(held));
            end
            nv_d = number_valid;
         end
      end
   end

   // One full round, entered and left on a negedge with the DUT in IDLE.
   // phase >= 0 waits until the first DRAW candidate is seq[phase].
   task automatic do_round(input bit h, input int phase, input bit ack_req, input int ack_delay);
      int w;
      if (phase >= 0) begin
         w = 0;
         while ((edge_cnt + 1) % 15 != phase && w < 20) begin
            @(negedge clk);
            w++;
         end
      end
      sb.push_back(model(edge_cnt, h));
      next_req = 1'b1;
      hard_mode = h;
      @(negedge clk);
      next_req = 1'b0;
      hard_mode = 1'($urandom);
      w = 0;
      while (number_valid !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (number_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got number_valid=%b expected 1 within 20 cycles", number_valid);
         finish_now();
      end
      repeat (ack_delay) @(negedge clk);
      ack = 1'b1;
      next_req = ack_req;
      @(negedge clk);
      ack = 1'b0;
      next_req = 1'b0;
      m_rounds = (m_rounds < 255) ? m_rounds + 1 : 255;
      check("round_cnt", 32'(round_cnt), m_rounds);
      if (ack_req) begin
         check("no_draw_busy", 32'(busy), 0);
         check("no_draw_valid", 32'(number_valid), 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_number", 32'(number), 0);
      check("rst_valid", 32'(number_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fallback", 32'(fallback), 0);
      check("rst_round_cnt", 32'(round_cnt), 0);
      rst = 1'b0;

      // First request right after release: candidate 2, hard mode.
      do_round(1'b1, -1, 1'b0, 0);
      // Easy draw from 13: 13 and 10 rejected, 5 accepted.
      do_round(1'b0, 6, 1'b0, 1);
      // Exactly 15 cycles later: 5 is a repeat, 11 is out of range, 7 accepted.
      do_round(1'b0, 8, 1'b0, 0);
      // Easy draw from 15: 15, 14, 12 rejected -> fallback 0.
      do_round(1'b0, 11, 1'b0, 0);
      // Previous stays 7 after fallback: 7 repeat, 15, 14 rejected -> fallback.
      do_round(1'b0, 10, 1'b0, 2);
      // ack together with next_req must not start a draw.
      do_round(1'b1, -1, 1'b1, 0);

      // Randomised rounds; enough of them to saturate round_cnt.
      repeat (280) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_round(1'($urandom), -1, 1'($urandom), $urandom_range(0, 2));
      end
      check("round_cnt_sat", 32'(round_cnt), 255);

      // Asynchronous reset in the middle of a draw.
      next_req = 1'b1;
      hard_mode = 1'b1;
      @(negedge clk);
      next_req = 1'b0;
      check("mid_draw_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(number_valid), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_number", 32'(number), 0);
      check("async_rst_round_cnt", 32'(round_cnt), 0);
      sb.delete();
      m_prev_valid = 1'b0;
      m_prev = 0;
      m_rounds = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      // LFSR restarted from 1, so the phase follows edge_cnt again.
      do_round(1'b1, -1, 1'b0, 0);
      do_round(1'b0, -1, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      finish_now();
   end

endmodule
